// File: rtl/chunked_add_sub_if.sv
// Start/done handshake bundle for chunked_add_sub: operands and opcode in,
// busy/done status and held result out.
interface chunked_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             Ofl;

    modport master (
        output start, A, B, C_in, sub,
        input  busy, done, S, C_out, Ofl
    );

    modport slave (
        input  start, A, B, C_in, sub,
        output busy, done, S, C_out, Ofl
    );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle two's-complement adder/subtractor, one CHUNK-bit ripple slice per clock.
// Optional signed saturation of the result is enabled by defining CHUNKED_ADD_SAT_EN.
module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst,
    chunked_add_sub_if.slave  bus
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [WIDTH-1:0]   partial_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   s_r;
    logic               c_out_r;
    logic               ofl_r;
    logic               busy_r;
    logic               done_r;

    int                 base_s;
    logic [CHUNK:0]     slice_s;
    logic [WIDTH-1:0]   partial_next_s;
    logic [WIDTH-1:0]   result_s;
    logic               ofl_s;
    logic               last_s;

    // Slice adder plus the final-result view used only at the done edge
    always_comb begin
        base_s         = int'(idx_r) * CHUNK;
        slice_s        = {1'b0, op_a_r[base_s +: CHUNK]}
                       + {1'b0, op_b_r[base_s +: CHUNK]}
                       + {{CHUNK{1'b0}}, carry_r};
        partial_next_s = partial_r;
        partial_next_s[base_s +: CHUNK] = slice_s[CHUNK-1:0];
        // op_b_r already holds ~B for subtraction, so one overflow rule covers both
        ofl_s  = (op_a_r[WIDTH-1] == op_b_r[WIDTH-1]) &&
                 (partial_next_s[WIDTH-1] != op_a_r[WIDTH-1]);
        last_s = (idx_r == IDX_W'(NCH - 1));
        result_s = partial_next_s;
`ifdef CHUNKED_ADD_SAT_EN
        if (ofl_s) begin
            if (op_a_r[WIDTH-1]) begin
                result_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                result_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            result_s = partial_next_s;
        end
`else
        result_s = partial_next_s;
`endif
    end

    // Control FSM, operand/carry pipeline and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            op_a_r    <= {WIDTH{1'b0}};
            op_b_r    <= {WIDTH{1'b0}};
            partial_r <= {WIDTH{1'b0}};
            carry_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            s_r       <= {WIDTH{1'b0}};
            c_out_r   <= 1'b0;
            ofl_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_a_r    <= bus.A;
                        op_b_r    <= bus.sub ? ~bus.B : bus.B;
                        carry_r   <= bus.sub ? 1'b1 : bus.C_in;
                        partial_r <= {WIDTH{1'b0}};
                        idx_r     <= {IDX_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= RUN;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                RUN: begin
                    partial_r <= partial_next_s;
                    carry_r   <= slice_s[CHUNK];
                    if (last_s) begin
                        s_r     <= result_s;
                        c_out_r <= slice_s[CHUNK];
                        ofl_r   <= ofl_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= IDLE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1'b1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.S     = s_r;
    assign bus.C_out = c_out_r;
    assign bus.Ofl   = ofl_r;
endmodule
